// File: rtl/ledcontroller_multi_if.sv
// Pin bundle between the board I2C open-drain halves, the strip data pins and the busy flag.
// No latency of its own; pure wiring.
// No flow control; SCL stretching is carried on scl_o.
interface ledcontroller_multi_if #(
  parameter int CHANNELS = 3
);
  logic                scl_i;
  logic                scl_o;
  logic                sda_i;
  logic                sda_o;
  logic [CHANNELS-1:0] led_o;
  logic                busy_o;

  // Board / bus-master side: drives the pin levels, observes the drives
  modport master (
    output scl_i, sda_i,
    input  scl_o, sda_o, led_o, busy_o
  );

  // Controller side
  modport slave (
    input  scl_i, sda_i,
    output scl_o, sda_o, led_o, busy_o
  );
endinterface

// File: rtl/ledcontroller_multi.sv
// I2C-slave-programmed multi-strip WS2812 driver with per-transaction channel select and broadcast refresh.
// Latency: serializer enters TX one clk after STOP/repeated-START commit; I2C inputs pass 2-FF sync + edge detect.
// Backpressure: SCL is stretched after a header/data ACK slot while a frame is being transmitted.
module ledcontroller_multi #(
  parameter logic [6:0] ADDRESS     = 7'h4A,
  parameter int         CHANNELS    = 3,
  parameter int         LED_CNT     = 3,
  parameter int         COLOR_BYTES = 3,
  parameter int         T0H         = 10,
  parameter int         T1H         = 20,
  parameter int         TBIT        = 31,
  parameter int         TRESET      = 1300
) (
  input logic                  clk,
  input logic                  reset,
  ledcontroller_multi_if.slave bus
);

  localparam int NBYTES = LED_CNT * COLOR_BYTES;
  localparam int PW     = $clog2(NBYTES + 1);
  localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [PW-1:0] NB_L       = PW'(NBYTES);
  localparam logic [PW-1:0] LAST_L     = PW'(NBYTES - 1);
  localparam logic [6:0]    CH_L       = 7'(CHANNELS);
  localparam logic [15:0]   T0H_L      = 16'(T0H);
  localparam logic [15:0]   T1H_L      = 16'(T1H);
  localparam logic [15:0]   TBIT_END   = 16'(TBIT - 1);
  localparam logic [15:0]   TRESET_END = 16'(TRESET - 1);

  typedef enum logic [1:0] {I_IDLE, I_ADDR, I_HDR, I_DATA} i2c_state_t;
  typedef enum logic [1:0] {S_IDLE, S_TX, S_LATCH} ser_state_t;

  // ---------------- input conditioning ----------------
  logic [1:0] scl_sync, sda_sync;
  logic       scl_q, sda_q;

  // Two-stage synchronisers plus one delayed copy for edge detection; idle bus level is high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_i};
      sda_sync <= {sda_sync[0], bus.sda_i};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  // ---------------- I2C slave ----------------
  i2c_state_t     i_state;
  logic [7:0]     shreg;
  logic [3:0]     bit_cnt;
  logic           in_ack;
  logic           sda_o_q, scl_o_q;
  logic           all_q, wrote_q;
  logic [CW-1:0]  ch_q;
  logic [PW-1:0]  ptr_q;
  logic [7:0]     frame_q [CHANNELS][NBYTES];
  logic           busy_q;

  // A bus STOP/START ends the transaction; it refreshes only if data actually landed
  logic                commit;
  logic [CHANNELS-1:0] commit_mask;
  assign commit      = (start_det | stop_det) & wrote_q;
  assign commit_mask = all_q ? {CHANNELS{1'b1}} : (CHANNELS'(1) << ch_q);

  // Byte receiver, ACK/NACK driver, frame buffer writes and SCL stretch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_state <= I_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      in_ack  <= 1'b0;
      sda_o_q <= 1'b1;
      scl_o_q <= 1'b1;
      all_q   <= 1'b0;
      wrote_q <= 1'b0;
      ch_q    <= '0;
      ptr_q   <= '0;
      for (int c = 0; c < CHANNELS; c++)
        for (int b = 0; b < NBYTES; b++)
          frame_q[c][b] <= '0;
    end else begin
      // Stretch ends as soon as the serializer is back to idle
      if (!scl_o_q && !busy_q)
        scl_o_q <= 1'b1;

      if (start_det) begin
        i_state <= I_ADDR;
        bit_cnt <= '0;
        in_ack  <= 1'b0;
        sda_o_q <= 1'b1;
        wrote_q <= 1'b0;
      end else if (stop_det) begin
        i_state <= I_IDLE;
        in_ack  <= 1'b0;
        sda_o_q <= 1'b1;
        wrote_q <= 1'b0;
      end else if (i_state != I_IDLE) begin
        if (scl_rise && !in_ack && bit_cnt != 4'd8) begin
          shreg   <= {shreg[6:0], sda_s};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (scl_fall && in_ack) begin
          // End of ACK slot; hold SCL low if the buffer is being streamed out
          in_ack  <= 1'b0;
          sda_o_q <= 1'b1;
          bit_cnt <= '0;
          if (i_state == I_DATA && busy_q)
            scl_o_q <= 1'b0;
        end else if (scl_fall && bit_cnt == 4'd8) begin
          case (i_state)
            I_ADDR: begin
              // Reads and foreign addresses are ignored until the next START
              if (shreg == {ADDRESS, 1'b0}) begin
                in_ack  <= 1'b1;
                sda_o_q <= 1'b0;
                i_state <= I_HDR;
              end else begin
                i_state <= I_IDLE;
              end
            end
            I_HDR: begin
              if (shreg[6:0] < CH_L) begin
                in_ack  <= 1'b1;
                sda_o_q <= 1'b0;
                i_state <= I_DATA;
                all_q   <= shreg[7];
                ch_q    <= CW'(shreg[6:0]);
                ptr_q   <= '0;
              end else begin
                i_state <= I_IDLE;
              end
            end
            I_DATA: begin
              // Past the end of the strip: NACK and drop, pointer parks at the end
              in_ack <= 1'b1;
              if (ptr_q != NB_L) begin
                sda_o_q              <= 1'b0;
                frame_q[ch_q][ptr_q] <= shreg;
                ptr_q                <= ptr_q + 1'b1;
                wrote_q              <= 1'b1;
              end
            end
            default: i_state <= I_IDLE;
          endcase
        end
      end
    end
  end

  // ---------------- WS2812 serializer ----------------
  ser_state_t          s_state;
  logic [CHANNELS-1:0] mask_q;
  logic [PW-1:0]       byte_idx;
  logic [2:0]          bit_idx;
  logic [15:0]         cnt;
  logic [CHANNELS-1:0] led_q, led_next;

  // Pulse shape for the current bit of every masked channel; unmasked strips stay low
  always_comb begin
    led_next = '0;
    for (int c = 0; c < CHANNELS; c++)
      led_next[c] = (s_state == S_TX) && mask_q[c] &&
                    (cnt < (frame_q[c][byte_idx][bit_idx] ? T1H_L : T0H_L));
  end

  // Shared bit/byte sequencing for all strips, then the latch gap; commits outside IDLE cannot occur (SCL is stretched)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_state  <= S_IDLE;
      mask_q   <= '0;
      byte_idx <= '0;
      bit_idx  <= 3'd7;
      cnt      <= '0;
      busy_q   <= 1'b0;
      led_q    <= '0;
    end else begin
      led_q <= led_next;
      case (s_state)
        S_IDLE: begin
          if (commit) begin
            s_state  <= S_TX;
            busy_q   <= 1'b1;
            mask_q   <= commit_mask;
            byte_idx <= '0;
            bit_idx  <= 3'd7;
            cnt      <= '0;
          end
        end
        S_TX: begin
          if (cnt == TBIT_END) begin
            cnt <= '0;
            if (bit_idx == 3'd0) begin
              bit_idx <= 3'd7;
              if (byte_idx == LAST_L)
                s_state <= S_LATCH;
              else
                byte_idx <= byte_idx + 1'b1;
            end else begin
              bit_idx <= bit_idx - 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_LATCH: begin
          if (cnt == TRESET_END) begin
            s_state <= S_IDLE;
            busy_q  <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: s_state <= S_IDLE;
      endcase
    end
  end

  assign bus.scl_o  = scl_o_q;
  assign bus.sda_o  = sda_o_q;
  assign bus.led_o  = led_q;
  assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_ledcontroller_multi.sv
// Directed bench for ledcontroller_multi: bit-banged I2C master on wired-AND lines, strip waveform decoder.
// Checks reset, unicast, address/header NACK, broadcast, overflow, stretch and mid-frame reset.
module tb_ledcontroller_multi;
  localparam int H = 20;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [7:0]  msg [$];
  logic [15:0] acks;
  logic [71:0] cap_d [3];
  int          cap_act [3];
  int          cap_bad, cap_gap;
  logic        cap_to;

  ledcontroller_multi_if #(.CHANNELS(3)) bus ();
  assign bus.scl_i = m_scl & bus.scl_o;
  assign bus.sda_i = m_sda & bus.sda_o;

  ledcontroller_multi #(
    .ADDRESS(7'h4A), .CHANNELS(3), .LED_CNT(3), .COLOR_BYTES(3),
    .T0H(10), .T1H(20), .TBIT(31), .TRESET(1300)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    int t;
    t = 0;
    m_scl = 1'b1;
    while (bus.scl_i !== 1'b1 && t < 6000) begin
      tick(1);
      t++;
    end
    if (t >= 6000) begin
      n_checks++;
      n_fail++;
      $display("FAIL scl_release: scl_i=%b after %0d clk, required 1", bus.scl_i, t);
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(H);
    scl_high();   tick(H);
    m_sda = 1'b0; tick(H);
    m_scl = 1'b0; tick(H);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(H);
    scl_high();   tick(H);
    m_sda = 1'b1; tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; tick(H);
      scl_high();   tick(H);
      m_scl = 1'b0; tick(4);
    end
    m_sda = 1'b1; tick(H);
    scl_high();   tick(H / 2);
    ack = (bus.sda_i === 1'b0);
    tick(H / 2);
    m_scl = 1'b0; tick(4);
  endtask

  task automatic xfer(output logic [15:0] a_out);
    logic a;
    a_out = '0;
    i2c_start();
    for (int i = 0; i < msg.size(); i++) begin
      send_byte(msg[i], a);
      a_out[i] = a;
    end
    i2c_stop();
  endtask

  // Decode one 72-bit frame on all strips: 31-clk windows from the first rising edge
  task automatic capture();
    int t, run;
    int hi [3];
    cap_to = 1'b0; cap_bad = 0; cap_gap = 0; run = 0;
    for (int c = 0; c < 3; c++) begin cap_d[c] = '0; cap_act[c] = 0; end
    t = 0;
    while (bus.led_o === 3'b000 && t < 4000) begin tick(1); t++; end
    if (t >= 4000) begin cap_to = 1'b1; return; end
    for (int w = 0; w < 72; w++) begin
      for (int c = 0; c < 3; c++) hi[c] = 0;
      for (int s = 0; s < 31; s++) begin
        for (int c = 0; c < 3; c++) if (bus.led_o[c] === 1'b1) hi[c]++;
        if (bus.led_o !== 3'b000) run = 0; else run++;
        tick(1);
      end
      for (int c = 0; c < 3; c++) begin
        if (hi[c] == 20)      begin cap_d[c][71-w] = 1'b1; cap_act[c]++; end
        else if (hi[c] == 10) begin cap_act[c]++; end
        else if (hi[c] != 0)  cap_bad++;
      end
    end
    t = 0;
    while (bus.busy_o === 1'b1 && t < 4000) begin
      if (bus.led_o !== 3'b000) begin run = 0; cap_bad++; end else run++;
      tick(1);
      t++;
    end
    if (t >= 4000) cap_to = 1'b1;
    cap_gap = run;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(5);
    n_checks++; if (bus.led_o !== 3'b000) begin n_fail++; $display("FAIL rst_led: got %b, required 000", bus.led_o); end
    n_checks++; if (bus.scl_o !== 1'b1) begin n_fail++; $display("FAIL rst_scl: got %b, required 1", bus.scl_o); end
    n_checks++; if (bus.sda_o !== 1'b1) begin n_fail++; $display("FAIL rst_sda: got %b, required 1", bus.sda_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", bus.busy_o); end
    reset = 1'b1;
    tick(1000);
    n_checks++; if (bus.led_o !== 3'b000) begin n_fail++; $display("FAIL idle_led: got %b, required 000", bus.led_o); end
    n_checks++; if (bus.scl_o !== 1'b1) begin n_fail++; $display("FAIL idle_scl: got %b, required 1", bus.scl_o); end
    n_checks++; if (bus.sda_o !== 1'b1) begin n_fail++; $display("FAIL idle_sda: got %b, required 1", bus.sda_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, required 0", bus.busy_o); end
  endtask

  task automatic test_unicast();
    msg = '{8'h94, 8'h01, 8'hAB, 8'h36, 8'h84, 8'hD0, 8'h25, 8'h5A, 8'h00, 8'h77, 8'h0D};
    xfer(acks);
    n_checks++; if (acks[10:0] !== 11'h7FF) begin n_fail++; $display("FAIL uni_acks: got %h, required 7ff", acks[10:0]); end
    capture();
    n_checks++; if (cap_to !== 1'b0) begin n_fail++; $display("FAIL uni_timeout: got %b, required 0", cap_to); end
    n_checks++; if (cap_d[1] !== 72'hAB3684D0255A00770D) begin n_fail++; $display("FAIL uni_frame1: got %h, required ab3684d0255a00770d", cap_d[1]); end
    n_checks++; if (cap_act[1] != 72) begin n_fail++; $display("FAIL uni_bits1: got %0d, required 72", cap_act[1]); end
    n_checks++; if (cap_act[0] != 0 || cap_act[2] != 0) begin n_fail++; $display("FAIL uni_quiet: got ch0=%0d ch2=%0d active bits, required 0", cap_act[0], cap_act[2]); end
    n_checks++; if (cap_bad != 0) begin n_fail++; $display("FAIL uni_shape: got %0d bad windows, required 0", cap_bad); end
    n_checks++; if (cap_gap < 1300) begin n_fail++; $display("FAIL uni_latch: got %0d low clk, required >=1300", cap_gap); end
  endtask

  task automatic test_bad_addr();
    msg = '{8'h96, 8'h01, 8'hAB};
    xfer(acks);
    n_checks++; if (acks[2:0] !== 3'b000) begin n_fail++; $display("FAIL addr_nack: got %b, required 000", acks[2:0]); end
    tick(100);
    n_checks++; if (bus.busy_o !== 1'b0 || bus.led_o !== 3'b000) begin n_fail++; $display("FAIL addr_notx: got busy=%b led=%b, required 0/000", bus.busy_o, bus.led_o); end
  endtask

  task automatic test_broadcast();
    msg = '{8'h94, 8'h03};
    xfer(acks);
    n_checks++; if (acks[1:0] !== 2'b01) begin n_fail++; $display("FAIL hdr_nack: got %b, required 01", acks[1:0]); end
    tick(100);
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL hdr_notx: got %b, required 0", bus.busy_o); end
    msg = '{8'h94, 8'h80, 8'hFF, 8'h00, 8'h0F};
    xfer(acks);
    n_checks++; if (acks[4:0] !== 5'h1F) begin n_fail++; $display("FAIL bc_acks: got %b, required 11111", acks[4:0]); end
    capture();
    n_checks++; if (cap_to !== 1'b0) begin n_fail++; $display("FAIL bc_timeout: got %b, required 0", cap_to); end
    n_checks++; if (cap_d[0] !== 72'hFF000F000000000000) begin n_fail++; $display("FAIL bc_frame0: got %h, required ff000f000000000000", cap_d[0]); end
    n_checks++; if (cap_d[1] !== 72'hAB3684D0255A00770D) begin n_fail++; $display("FAIL bc_frame1: got %h, required ab3684d0255a00770d", cap_d[1]); end
    n_checks++; if (cap_d[2] !== 72'h0) begin n_fail++; $display("FAIL bc_frame2: got %h, required 0", cap_d[2]); end
    n_checks++; if (cap_act[0] != 72 || cap_act[1] != 72 || cap_act[2] != 72) begin n_fail++; $display("FAIL bc_lockstep: got %0d/%0d/%0d bits, required 72 each", cap_act[0], cap_act[1], cap_act[2]); end
    n_checks++; if (cap_bad != 0) begin n_fail++; $display("FAIL bc_shape: got %0d bad windows, required 0", cap_bad); end
  endtask

  task automatic test_overflow();
    msg = '{8'h94, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    xfer(acks);
    n_checks++; if (acks[11:0] !== 12'h7FF) begin n_fail++; $display("FAIL ovf_acks: got %h, required 7ff", acks[11:0]); end
    capture();
    n_checks++; if (cap_to !== 1'b0) begin n_fail++; $display("FAIL ovf_timeout: got %b, required 0", cap_to); end
    n_checks++; if (cap_d[0] !== 72'h112233445566778899) begin n_fail++; $display("FAIL ovf_frame0: got %h, required 112233445566778899", cap_d[0]); end
    n_checks++; if (cap_act[1] != 0 || cap_act[2] != 0) begin n_fail++; $display("FAIL ovf_quiet: got ch1=%0d ch2=%0d active bits, required 0", cap_act[1], cap_act[2]); end
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2;
    int   t;
    msg = '{8'h94, 8'h01, 8'h5C};
    xfer(acks);
    i2c_start();
    send_byte(8'h94, a0);
    send_byte(8'h02, a1);
    n_checks++; if ({a0, a1} !== 2'b11) begin n_fail++; $display("FAIL b2b_acks: got %b, required 11", {a0, a1}); end
    fork
      send_byte(8'h3C, a2);
      begin
        tick(H + 10);
        n_checks++; if (bus.scl_o !== 1'b0) begin n_fail++; $display("FAIL b2b_stretch: got scl_o=%b, required 0", bus.scl_o); end
        n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b, required 1", bus.busy_o); end
        t = 0;
        while (bus.scl_o !== 1'b1 && t < 6000) begin tick(1); t++; end
        n_checks++; if (bus.busy_o !== 1'b0 || t >= 6000) begin n_fail++; $display("FAIL b2b_release: got busy=%b after %0d clk, required 0", bus.busy_o, t); end
      end
    join
    n_checks++; if (a2 !== 1'b1) begin n_fail++; $display("FAIL b2b_data_ack: got %b, required 1", a2); end
    i2c_stop();
    t = 0;
    while (bus.led_o === 3'b000 && t < 4000) begin tick(1); t++; end
    n_checks++; if (bus.led_o !== 3'b100) begin n_fail++; $display("FAIL b2b_tx: got led=%b, required 100", bus.led_o); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (bus.led_o !== 3'b000 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL midtx_reset: got led=%b busy=%b, required 000/0", bus.led_o, bus.busy_o); end
    tick(3);
    reset = 1'b1;
    tick(10);
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_bad_addr();
    test_broadcast();
    test_overflow();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
